psum_accum_quant: RTL and testbench

Output stage of a PE column: consumes the 20-bit partial sum from the last PE in the chain, accumulates it across input-channel passes in a per-position accumulator bank, and, on the final pass, adds bias, applies ReLU, right-shifts and saturates to an 8-bit unsigned activation. The result goes to the ofmap buffer, or back in as the next layer's ifmap. It sits directly downstream of the PE chain's `psumOut`.

---
 rtl/psum_accum_quant.sv | 130 +++++++++++++
 tb/tb_psum_accum_quant.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/psum_accum_quant.sv
// PE-column output stage: per-position psum accumulation, then bias/ReLU/shift/clamp to uint8.
// Result valid 2 cycles after an in_last beat; no backpressure, one beat per cycle.
module psum_accum_quant #(
  parameter int DEPTH = 16,
  parameter int ACC_W = 24,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [19:0]   psum_in,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [15:0]   bias,
  input  logic [3:0]    shift,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic [AW-1:0] out_addr,
  output logic          row_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;
  logic [AW-1:0] ptr;
  logic          wrap;
  logic          beat;

  logic signed [ACC_W-1:0] acc [DEPTH];
  logic signed [19:0]      psum_s;
  logic signed [ACC_W-1:0] ext, cur, sum;
  logic signed [ACC_W:0]   wide;

  logic                    s1_vld;
  logic signed [ACC_W-1:0] s1_sum;
  logic [AW-1:0]           s1_addr;
  logic signed [15:0]      s1_bias;
  logic [3:0]              s1_shift;
  logic signed [ACC_W:0]   q_pre, q;
  logic [7:0]              q8;

  assign wrap   = (ptr == AW'(DEPTH - 1));
  assign beat   = in_valid && !rst && !clear;
  assign psum_s = psum_in;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (in_valid && in_last && wrap) state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr      <= '0;
      row_done <= 1'b0;
    end else begin
      row_done <= in_valid && wrap;
      if (in_valid) ptr <= wrap ? '0 : ptr + AW'(1);
    end
  end

  // Accumulate with saturation; the wide sum carries one guard bit for overflow detection.
  always_comb begin
    ext  = ACC_W'(psum_s);
    cur  = acc[ptr];
    wide = (ACC_W+1)'(cur) + (ACC_W+1)'(ext);
    if (in_first)
      sum = ext;
    else if (wide[ACC_W] != wide[ACC_W-1])
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum = wide[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (beat) acc[ptr] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) s1_vld <= 1'b0;
    else              s1_vld <= in_valid && in_last;
  end

  always_ff @(posedge clk) begin
    if (beat && in_last) begin
      s1_sum   <= sum;
      s1_addr  <= ptr;
      s1_bias  <= bias;
      s1_shift <= shift;
    end
  end

  // Floor shift at ACC_W+1 bits, then ReLU and clamp to 0..255.
  always_comb begin
    q_pre = (ACC_W+1)'(s1_sum) + (ACC_W+1)'(s1_bias);
    q     = q_pre >>> s1_shift;
    if (q[ACC_W])
      q8 = 8'd0;
    else if (|q[ACC_W-1:8])
      q8 = 8'd255;
    else
      q8 = q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data <= q8;
        out_addr <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_quant.sv
// Randomized bench for psum_accum_quant against an arithmetic reference of accumulate/quantize.
module tb_psum_accum_quant;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_first, in_last;
  logic [19:0] psum_in;
  logic [15:0] bias;
  logic [3:0]  shift;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_addr;
  logic        row_done;

  psum_accum_quant #(.DEPTH(16), .ACC_W(24), .AW(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .psum_in(psum_in),
    .in_first(in_first), .in_last(in_last), .bias(bias), .shift(shift),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .row_done(row_done)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int addr; int data;} exp_t;

  localparam longint MAXA = 8388607;
  localparam longint MINA = -8388608;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     ptr_m = 0;
  longint acc_m [16];
  exp_t   eq [$];
  int     rd [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int quant(input longint s, input longint b, input int sh);
    longint v;
    v = (s + b) >>> sh;
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic check_outputs();
    logic ev, er;
    ev = (eq.size() > 0) && (eq[0].due == cyc);
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("out_addr", 32'(out_addr), eq[0].addr);
      chk("out_data", 32'(out_data), eq[0].data);
      void'(eq.pop_front());
    end
    er = (rd.size() > 0) && (rd[0] == cyc);
    chk("row_done", 32'(row_done), 32'(er));
    if (er) void'(rd.pop_front());
  endtask

  task automatic step(input logic v, input logic rs, input logic cl, input logic [19:0] p,
                      input logic f, input logic l, input logic [15:0] b, input logic [3:0] sh);
    longint e, s;
    rst = rs; clear = cl; in_valid = v; psum_in = p;
    in_first = f; in_last = l; bias = b; shift = sh;
    if (rs || cl) begin
      eq.delete();
      rd.delete();
      ptr_m = 0;
    end else if (v) begin
      e = longint'($signed(p));
      s = f ? e : acc_m[ptr_m] + e;
      if (s > MAXA) s = MAXA;
      if (s < MINA) s = MINA;
      acc_m[ptr_m] = s;
      if (l) eq.push_back('{cyc + 2, ptr_m, quant(s, longint'($signed(b)), int'(sh))});
      if (ptr_m == 15) rd.push_back(cyc + 1);
      ptr_m = (ptr_m + 1) % 16;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic beat(input logic [19:0] p, input logic f, input logic l,
                      input logic [15:0] b, input logic [3:0] sh);
    step(1'b1, 1'b0, 1'b0, p, f, l, b, sh);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 16'd0, 4'd0);
  endtask

  initial begin
    int pv [3];
    pv[0] = 100; pv[1] = 200; pv[2] = -50;

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 16'd0, 4'd0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    idle(2);

    // Single pass identity
    for (int i = 0; i < 16; i++) beat(20'(i), 1'b1, 1'b1, 16'd0, 4'd0);
    idle(3);

    // Three passes: (100+200-50+10)>>>2 = 65, output on the last pass only
    for (int ps = 0; ps < 3; ps++)
      for (int i = 0; i < 16; i++)
        beat(20'(pv[ps]), ps == 0, ps == 2, 16'd10, 4'd2);
    idle(3);

    // ReLU / clamp corners, then random fill of the row
    beat(20'hFFFFF, 1'b1, 1'b1, 16'd0, 4'd0);
    beat(20'd300,   1'b1, 1'b1, 16'd0, 4'd0);
    beat(20'h7FFFF, 1'b1, 1'b1, 16'd0, 4'd15);
    beat(20'd32767, 1'b1, 1'b1, 16'h8000, 4'd0);
    for (int i = 4; i < 16; i++)
      beat(20'($urandom), 1'b1, 1'b1, 16'($urandom), 4'($urandom));
    idle(3);

    // Accumulator saturation over 40 passes
    for (int ps = 0; ps < 40; ps++)
      for (int i = 0; i < 16; i++)
        beat(20'h7FFFF, ps == 0, ps == 39, 16'd0, 4'd15);
    idle(3);

    // rst (mode 0) / clear (mode 1) mid-row with an in_last beat in flight
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 8; i++) beat(20'($urandom_range(0, 500)), 1'b1, 1'b1, 16'd0, 4'd0);
      step(1'b1, mode == 0, mode == 1, 20'd77, 1'b1, 1'b1, 16'd0, 4'd0);
      idle(2);
      for (int i = 0; i < 16; i++) beat(20'($urandom_range(0, 255)), 1'b1, 1'b1, 16'd0, 4'd0);
      idle(3);
    end

    // Two-pass rows with random gaps
    for (int rep = 0; rep < 4; rep++) begin
      for (int ps = 0; ps < 2; ps++)
        for (int i = 0; i < 16; i++) begin
          idle($urandom_range(0, 3));
          beat(20'($urandom), ps == 0, ps == 1, 16'($urandom), 4'($urandom));
        end
    end
    idle(4);
    chk("queue_drained", eq.size(), 0);
    chk("row_done_drained", rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
